uart_tx_sched: RTL

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_pkg.sv | 19 +
 rtl/uart_tx_sched_rr_arb2.sv | 36 +++
 rtl/uart_tx_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler, its arbiter and its bench.
// No logic; constants and the scheduler state encoding only.
// No flow control here; see the modules that import it.
package uart_tx_sched_pkg;

    localparam int WORD_SIZE_DEF    = 8;
    localparam int FRAME_CYCLES_DEF = 12;
    localparam int TX_COUNT_W       = 16;

    // One frame walks LOAD -> ARM -> START -> WAIT and returns to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARM   = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
// Grants are combinational (0 cycles); last_grant updates at the edge where take=1.
// No backpressure of its own: the caller decides via take whether a grant is consumed.
module rr_arb2 (
    input  logic Clock,
    input  logic rst_b,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt0,
    output logic gnt1
);

    // 1 means req1 was granted last, so req0 wins the first tie out of reset.
    logic last_grant;

    // Priority goes to whichever requester was not served last.
    always_comb begin
        gnt0 = req0 & (~req1 | last_grant);
        gnt1 = req1 & (~req0 | ~last_grant);
    end

    // Remember the winner only when the grant is actually consumed.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            last_grant <= 1'b1;
        end else if (take) begin
            if (gnt0) begin
                last_grant <= 1'b0;
            end else if (gnt1) begin
                last_grant <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules bytes from two requesters onto one UART transmitter with load/arm/start pulses.
// Grant in IDLE, pulses 1/2/3 cycles later, then FRAME_CYCLES of WAIT: FRAME_CYCLES+4 per byte.
// Ready is offered only in IDLE with en high; requesters simply hold valid until ready.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    // Must be at least WORD_SIZE+2 so the start, data and stop bits fit in WAIT.
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic                  Clock,
    input  logic                  rst_b,
    input  logic                  en,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    input  logic [WORD_SIZE-1:0]  req0_data,
    input  logic [WORD_SIZE-1:0]  req1_data,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic [WORD_SIZE-1:0]  Data_Bus,
    output logic                  Load_XMT_datareg,
    output logic                  Byte_ready,
    output logic                  T_byte,
    output logic                  busy,
    output logic [TX_COUNT_W-1:0] tx_count
);

    localparam int CW = $clog2(FRAME_CYCLES + 1);

    sched_state_t  state;
    sched_state_t  state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          gnt0;
    logic          gnt1;
    logic          can_grant;
    logic          take;

    // rst_b gates the offer so nothing is granted while reset is held.
    assign can_grant  = rst_b & en & (state == IDLE);
    assign take       = can_grant & (gnt0 | gnt1);
    assign req0_ready = can_grant & gnt0;
    assign req1_ready = can_grant & gnt1;
    assign busy       = (state != IDLE);

    rr_arb2 u_arb (
        .Clock (Clock),
        .rst_b (rst_b),
        .req0  (req0_valid),
        .req1  (req1_valid),
        .take  (take),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // State register.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the one-cycle transmitter pulses decoded from the current state.
    always_comb begin
        state_nxt        = state;
        Load_XMT_datareg = 1'b0;
        Byte_ready       = 1'b0;
        T_byte           = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                Load_XMT_datareg = 1'b1;
                state_nxt        = ARM;
            end
            ARM: begin
                Byte_ready = 1'b1;
                state_nxt  = START;
            end
            START: begin
                T_byte    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == CW'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the granted byte; it is held untouched until the next grant.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            Data_Bus <= '0;
        end else if (take) begin
            Data_Bus <= gnt0 ? req0_data : req1_data;
        end
    end

    // WAIT length: loaded in START, counts down, WAIT exits on the cycle it reads 1.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            wait_cnt <= '0;
        end else if (state == START) begin
            wait_cnt <= CW'(FRAME_CYCLES);
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - CW'(1);
        end
    end

    // Frames started: bumps on the edge leaving ARM, i.e. on entry to START; wraps naturally.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            tx_count <= '0;
        end else if (state == ARM) begin
            tx_count <= tx_count + TX_COUNT_W'(1);
        end
    end

endmodule
